flopfifo: RTL and testbench



---
 rtl/flopfifo_pkg.sv | 12 +
 rtl/flopfifo_fifoptr.sv | 24 ++
 rtl/flopfifo.sv | 82 ++++++++
 tb/tb_flopfifo.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/flopfifo_pkg.sv
// Shared constants and helpers for the flopfifo block.
package flopfifo_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_DEPTH = 4;

    // Pointer width for a modulo-d pointer.
    function automatic int fifo_ptrw(input int d);
        return (d > 1) ? $clog2(d) : 1;
    endfunction

endpackage

// File: rtl/flopfifo_fifoptr.sv
// Modulo-N pointer register with synchronous reset/clear and increment enable.
module fifoptr
    import flopfifo_pkg::*;
#(
    parameter int N = DEFAULT_DEPTH
) (
    input  logic                    ph1,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    inc,
    output logic [fifo_ptrw(N)-1:0] ptr
);

    localparam int PW = fifo_ptrw(N);

    always_ff @(posedge ph1) begin
        if (reset || clear) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= (ptr == PW'(N - 1)) ? '0 : ptr + 1'b1;
        end
    end

endmodule

// File: rtl/flopfifo.sv
// Synchronous show-ahead FIFO with occupancy count and sticky misuse flag.
module flopfifo
    import flopfifo_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                      ph1,
    input  logic                      reset,
    input  logic                      clear,
    input  logic                      wr_en,
    input  logic [WIDTH-1:0]          wr_data,
    input  logic                      rd_en,
    output logic [WIDTH-1:0]          rd_data,
    output logic                      empty,
    output logic                      full,
    output logic [fifo_ptrw(DEPTH):0] count,
    output logic                      err
);

    localparam int PW = fifo_ptrw(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wp;
    logic [PW-1:0]    rp;
    logic [DEPTH-1:0] we;
    logic             push;
    logic             pop;
    logic             bad_push;
    logic             bad_pop;

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    // A full FIFO still accepts a push when a pop frees the head slot this edge.
    assign push     = wr_en && (!full || rd_en);
    assign pop      = rd_en && !empty;
    assign bad_push = wr_en && full && !rd_en;
    assign bad_pop  = rd_en && empty && !wr_en;

    fifoptr #(.N(DEPTH)) u_wp (
        .ph1   (ph1),
        .reset (reset),
        .clear (clear),
        .inc   (push),
        .ptr   (wp)
    );

    fifoptr #(.N(DEPTH)) u_rp (
        .ph1   (ph1),
        .reset (reset),
        .clear (clear),
        .inc   (pop),
        .ptr   (rp)
    );

    // NOTE: default every always_comb output first so no latch is inferred.
    always_comb begin
        we = '0;
        if (push) we[wp] = 1'b1;
    end

    // NOTE: storage has no reset; emptiness is tracked by count, and rd_data is forced to 0 when empty.
    always_ff @(posedge ph1) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (we[i]) mem[i] <= wr_data;
        end
    end

    always_ff @(posedge ph1) begin
        if (reset || clear) begin
            count <= '0;
            err   <= 1'b0;
        end else begin
            count <= count + CW'(push) - CW'(pop);
            if (bad_push || bad_pop) err <= 1'b1;
        end
    end

    assign rd_data = empty ? '0 : mem[rp];

endmodule

// File: tb/tb_flopfifo.sv
// Self-checking bench: directed table on a 32x4 FIFO, random scoreboard run on an 8x8 FIFO.
module tb_flopfifo;

    logic ph1 = 1'b0;
    always #5 ph1 = ~ph1;

    // DUT A: WIDTH=32, DEPTH=4
    logic        a_reset, a_clear, a_wr, a_rd;
    logic [31:0] a_wdata, a_rdata;
    logic        a_empty, a_full, a_err;
    logic [2:0]  a_count;

    flopfifo #(.WIDTH(32), .DEPTH(4)) dut_a (
        .ph1(ph1), .reset(a_reset), .clear(a_clear), .wr_en(a_wr), .wr_data(a_wdata),
        .rd_en(a_rd), .rd_data(a_rdata), .empty(a_empty), .full(a_full),
        .count(a_count), .err(a_err)
    );

    // DUT B: WIDTH=8, DEPTH=8
    logic       b_reset, b_clear, b_wr, b_rd;
    logic [7:0] b_wdata, b_rdata;
    logic       b_empty, b_full, b_err;
    logic [3:0] b_count;

    flopfifo #(.WIDTH(8), .DEPTH(8)) dut_b (
        .ph1(ph1), .reset(b_reset), .clear(b_clear), .wr_en(b_wr), .wr_data(b_wdata),
        .rd_en(b_rd), .rd_data(b_rdata), .empty(b_empty), .full(b_full),
        .count(b_count), .err(b_err)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge ph1);
        #1;
    endtask

    typedef struct {
        logic        rst;
        logic        clr;
        logic        wr;
        logic        rd;
        logic [31:0] data;
        int          exp_count;
        logic [31:0] exp_rd;
        logic        exp_err;
        string       name;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rst, input logic clr, input logic wr, input logic rd,
                                input logic [31:0] data, input int c, input logic [31:0] r,
                                input logic e, input string name);
        vec_t v;
        v.rst = rst; v.clr = clr; v.wr = wr; v.rd = rd; v.data = data;
        v.exp_count = c; v.exp_rd = r; v.exp_err = e; v.name = name;
        return v;
    endfunction

    // Reference model for DUT B: a queue plus a sticky flag.
    logic [7:0] q[$];
    logic       m_err;

    task automatic model_step(input logic rst, input logic clr, input logic wr,
                              input logic [7:0] d, input logic rd);
        bit can_push, can_pop;
        if (rst || clr) begin
            q.delete();
            m_err = 1'b0;
        end else begin
            can_push = wr && (q.size() < 8 || rd);
            can_pop  = rd && q.size() != 0;
            if (wr && !can_push) m_err = 1'b1;
            if (rd && q.size() == 0 && !wr) m_err = 1'b1;
            if (can_pop) void'(q.pop_front());
            if (can_push) q.push_back(d);
        end
    endtask

    initial begin
        logic [31:0] prev;
        logic [31:0] nxt;

        a_reset = 1'b1; a_clear = 1'b0; a_wr = 1'b0; a_rd = 1'b0; a_wdata = '0;
        b_reset = 1'b1; b_clear = 1'b0; b_wr = 1'b0; b_rd = 1'b0; b_wdata = '0;

        //               rst clr wr rd data   cnt rd_data err
        vecs.push_back(mk(1, 0, 0, 0, 32'h0,  0, 32'h0,  0, "reset"));
        vecs.push_back(mk(0, 0, 1, 0, 32'h11, 1, 32'h11, 0, "fill1"));
        vecs.push_back(mk(0, 0, 1, 0, 32'h22, 2, 32'h11, 0, "fill2"));
        vecs.push_back(mk(0, 0, 1, 0, 32'h33, 3, 32'h11, 0, "fill3"));
        vecs.push_back(mk(0, 0, 1, 0, 32'h44, 4, 32'h11, 0, "fill4"));
        vecs.push_back(mk(0, 0, 0, 1, 32'h0,  3, 32'h22, 0, "drain1"));
        vecs.push_back(mk(0, 0, 0, 1, 32'h0,  2, 32'h33, 0, "drain2"));
        vecs.push_back(mk(0, 0, 0, 1, 32'h0,  1, 32'h44, 0, "drain3"));
        vecs.push_back(mk(0, 0, 0, 1, 32'h0,  0, 32'h0,  0, "drain4"));
        vecs.push_back(mk(0, 0, 1, 0, 32'h01, 1, 32'h01, 0, "ovf_fill1"));
        vecs.push_back(mk(0, 0, 1, 0, 32'h02, 2, 32'h01, 0, "ovf_fill2"));
        vecs.push_back(mk(0, 0, 1, 0, 32'h03, 3, 32'h01, 0, "ovf_fill3"));
        vecs.push_back(mk(0, 0, 1, 0, 32'h04, 4, 32'h01, 0, "ovf_fill4"));
        vecs.push_back(mk(0, 0, 1, 0, 32'h55, 4, 32'h01, 1, "overflow"));
        vecs.push_back(mk(0, 0, 0, 1, 32'h0,  3, 32'h02, 1, "ovf_sticky"));
        vecs.push_back(mk(0, 1, 0, 0, 32'h0,  0, 32'h0,  0, "clear"));
        vecs.push_back(mk(0, 0, 1, 0, 32'h0A, 1, 32'h0A, 0, "pt_fill1"));
        vecs.push_back(mk(0, 0, 1, 0, 32'h0B, 2, 32'h0A, 0, "pt_fill2"));
        vecs.push_back(mk(0, 0, 1, 0, 32'h0C, 3, 32'h0A, 0, "pt_fill3"));
        vecs.push_back(mk(0, 0, 1, 0, 32'h0D, 4, 32'h0A, 0, "pt_fill4"));
        vecs.push_back(mk(0, 0, 1, 1, 32'h0E, 4, 32'h0B, 0, "pass_through"));
        vecs.push_back(mk(0, 0, 0, 1, 32'h0,  3, 32'h0C, 0, "pt_drain1"));
        vecs.push_back(mk(0, 0, 0, 1, 32'h0,  2, 32'h0D, 0, "pt_drain2"));
        vecs.push_back(mk(0, 0, 0, 1, 32'h0,  1, 32'h0E, 0, "pt_drain3"));
        vecs.push_back(mk(0, 0, 0, 1, 32'h0,  0, 32'h0,  0, "pt_drain4"));
        vecs.push_back(mk(0, 0, 1, 1, 32'h77, 1, 32'h77, 0, "empty_both"));
        vecs.push_back(mk(0, 0, 0, 1, 32'h0,  0, 32'h0,  0, "empty_pop"));
        vecs.push_back(mk(0, 0, 0, 1, 32'h0,  0, 32'h0,  1, "underflow"));
        vecs.push_back(mk(0, 0, 1, 0, 32'h66, 1, 32'h66, 1, "udf_sticky"));
        vecs.push_back(mk(0, 1, 1, 1, 32'h99, 0, 32'h0,  0, "clear_ignores"));
        vecs.push_back(mk(0, 0, 1, 0, 32'h1,  1, 32'h1,  0, "burst1"));
        vecs.push_back(mk(0, 0, 1, 0, 32'h2,  2, 32'h1,  0, "burst2"));
        vecs.push_back(mk(0, 0, 1, 0, 32'h3,  3, 32'h1,  0, "burst3"));
        vecs.push_back(mk(1, 0, 1, 0, 32'h9,  0, 32'h0,  0, "reset_mid"));
        vecs.push_back(mk(0, 0, 1, 0, 32'h5A, 1, 32'h5A, 0, "post_reset"));
        vecs.push_back(mk(0, 0, 1, 0, 32'h5B, 2, 32'h5A, 0, "wrap_pre"));

        for (int i = 0; i < vecs.size(); i++) begin
            a_reset = vecs[i].rst; a_clear = vecs[i].clr;
            a_wr = vecs[i].wr; a_rd = vecs[i].rd; a_wdata = vecs[i].data;
            step();
            check({vecs[i].name, ".count"}, 32'(a_count), 32'(vecs[i].exp_count));
            check({vecs[i].name, ".rd_data"}, a_rdata, vecs[i].exp_rd);
            check({vecs[i].name, ".err"}, 32'(a_err), 32'(vecs[i].exp_err));
            check({vecs[i].name, ".empty"}, 32'(a_empty), 32'(vecs[i].exp_count == 0));
            check({vecs[i].name, ".full"}, 32'(a_full), 32'(vecs[i].exp_count == 4));
        end

        // Wrap-around at occupancy 2: FIFO holds 0x5A,0x5B; keep pushing an incrementing pattern.
        prev = 32'h5A;
        nxt  = 32'h5C;
        for (int i = 0; i < 10; i++) begin
            a_reset = 1'b0; a_clear = 1'b0; a_wr = 1'b1; a_rd = 1'b1; a_wdata = nxt;
            step();
            check("wrap.count", 32'(a_count), 32'd2);
            check("wrap.order", a_rdata, prev + 32'd1);
            prev = a_rdata;
            nxt  = nxt + 32'd1;
        end
        a_wr = 1'b0; a_rd = 1'b1;
        step();
        check("wrap.tail1", a_rdata, 32'h65);
        step();
        check("wrap.tail2", a_rdata, 32'h0);
        check("wrap.empty", 32'(a_empty), 32'd1);
        a_rd = 1'b0;

        // Random run on DUT B against the queue model.
        model_step(1'b1, 1'b0, 1'b0, 8'h0, 1'b0);
        step();
        b_reset = 1'b0;
        for (int i = 0; i < 600; i++) begin
            b_reset = ($urandom_range(0, 199) == 0);
            b_clear = ($urandom_range(0, 99) == 0);
            b_wr    = ($urandom_range(0, 99) < 55);
            b_rd    = ($urandom_range(0, 99) < 45);
            b_wdata = 8'($urandom);
            model_step(b_reset, b_clear, b_wr, b_wdata, b_rd);
            step();
            check("rand.count", 32'(b_count), 32'(q.size()));
            check("rand.rd_data", 32'(b_rdata), (q.size() != 0) ? 32'(q[0]) : 32'h0);
            check("rand.err", 32'(b_err), 32'(m_err));
            check("rand.empty", 32'(b_empty), 32'(q.size() == 0));
            check("rand.full", 32'(b_full), 32'(q.size() == 8));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
